reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor to the two-read/one-write register file for the pipelined core.
- Adds a per-register pending-write scoreboard so decode can detect RAW hazards on in-flight writes.
- Adds same-cycle writeback-to-read bypass and an underflow error flag.
- Sits in decode: read addresses come from instruction fields, issue marks the destination, writeback retires it.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; must be a power of 2, 2 to 64.
- AW, $clog2(NREGS), register address width.
- PEND_W, 2, pending-counter width per register; max in-flight writes per register = 2^PEND_W-1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- address_rd1  in  AW  read port 1 address.
- address_rd2  in  AW  read port 2 address.
- rdata1  out  XLEN  read port 1 data (combinational).
- rdata2  out  XLEN  read port 2 data (combinational).
- rs1_busy  out  1  port 1 register has an unretired pending write.
- rs2_busy  out  1  port 2 register has an unretired pending write.
- issue_en  in  1  request to mark a destination register pending.
- issue_rd  in  AW  destination register of the issuing instruction.
- issue_ok  out  1  combinational; issue is accepted this cycle.
- wr_en  in  1  writeback valid.
- address_wr  in  AW  writeback destination.
- data_in  in  XLEN  writeback data.
- err_underflow  out  1  registered, sticky; writeback retired a register with zero pending count.

Behaviour:
- Reset (async, active-high): all registers 0, all pending counters 0, err_underflow 0. Reset mid-operation discards all in-flight pending state immediately. While reset is high, rdata* = 0 and rs*_busy = 0.
- Register 0 is hardwired:
  - reads return 0;
  - writes are ignored;
  - its counter is never incremented;
  - issue_rd = 0 always gives issue_ok = 1 with no state change;
  - wr_en with address_wr = 0 does nothing, including no underflow.
- Write: at posedge, if wr_en and address_wr != 0, reg[address_wr] <= data_in.
- Read and bypass, per port:
  - if wr_en and address_wr == address_rdN and address_rdN != 0, rdataN = data_in;
  - else rdataN = reg[address_rdN].
  - Zero-cycle latency.
- Pending counter cnt[r] for r != 0, per posedge:
  - inc = issue_en & issue_ok & (issue_rd == r)
  - dec = wr_en & (address_wr == r) & (cnt[r] != 0)
  - inc & dec: unchanged. inc only: +1. dec only: -1.
- issue_ok = !(cnt[issue_rd] == 2^PEND_W-1 and no dec of issue_rd this cycle). A full counter freed by a same-cycle writeback accepts the issue.
- rsN_busy = (address_rdN != 0) and cnt[address_rdN] != 0, except 0 when cnt == 1 and a dec hits that register this cycle, since the bypass supplies the value.
- Underflow: wr_en, address_wr != 0, cnt[address_wr] == 0 → register still written, counter stays 0, err_underflow <= 1. It stays set until reset.
- Counters never wrap: no increment past max (issue_ok gates it), no decrement below 0.
- rdata*, rs*_busy and issue_ok are purely combinational from current state and inputs. No combinational path from issue_* to rdata*.

Test Plan:
- Reset then read all 32 registers → every rdata = 0, rs*_busy = 0, err_underflow = 0. Assert reset mid-run after writes → all reads 0 immediately, without a clock.
- Issue rd=5, then next cycle read rs1=5 → rs1_busy=1. Writeback address_wr=5 data_in=0xDEADBEEF with address_rd1=5 in the same cycle → rdata1=0xDEADBEEF, rs1_busy=0. Next cycle reg[5]=0xDEADBEEF, busy=0.
- Issue rd=7 three times (PEND_W=2) → cnt=3. Fourth issue → issue_ok=0, cnt stays 3. Fourth issue in the same cycle as a writeback to 7 → issue_ok=1, cnt stays 3.
- Writeback 0x1234 to r0 with address_rd2=0 → rdata2=0 both that cycle and after. Issue rd=0 → issue_ok=1, rs2_busy stays 0.
- Writeback to r9 with cnt=0, data 0x55 → reg[9]=0x55, cnt=0, err_underflow=1 next cycle and stays 1 until reset.
- Issue rd=3 and writeback to r3 (cnt=1) in the same cycle → cnt stays 1, rs1_busy=1 for address_rd1=3 on the next cycle.

Source files
------------

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with per-register pending-write scoreboard,
// writeback-to-read bypass and a sticky underflow flag for decode-stage hazard detection.
module reg_file_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned AW     = $clog2(NREGS),
    parameter int unsigned PEND_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   address_rd1,
    input  logic [AW-1:0]   address_rd2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ok,
    input  logic            wr_en,
    input  logic [AW-1:0]   address_wr,
    input  logic [XLEN-1:0] data_in,
    output logic            err_underflow
);

    localparam int unsigned PEND_MAX = (1 << PEND_W) - 1;

    logic [XLEN-1:0]   regs_q [NREGS];
    logic [PEND_W-1:0] cnt_q  [NREGS];
    logic [PEND_W-1:0] cnt_d  [NREGS];
    logic              err_q;
    logic              err_d;

    logic wr_live;
    logic dec_issue;
    logic dec_rd1;
    logic dec_rd2;

    // Writeback to any non-zero register; r0 writes are dropped entirely.
    assign wr_live = wr_en && (address_wr != '0);

    // A writeback retires one pending write only if the counter is non-zero.
    assign dec_issue = wr_en && (address_wr == issue_rd)    && (cnt_q[issue_rd]    != '0);
    assign dec_rd1   = wr_en && (address_wr == address_rd1) && (cnt_q[address_rd1] != '0);
    assign dec_rd2   = wr_en && (address_wr == address_rd2) && (cnt_q[address_rd2] != '0);

    assign issue_ok = (issue_rd == '0) ||
                      !((cnt_q[issue_rd] == PEND_W'(PEND_MAX)) && !dec_issue);

    // Read ports: same-cycle writeback bypass, outputs held at zero during reset.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (!reset) begin
            if (wr_live && (address_wr == address_rd1)) rdata1 = data_in;
            else if (address_rd1 != '0)                 rdata1 = regs_q[address_rd1];
            if (wr_live && (address_wr == address_rd2)) rdata2 = data_in;
            else if (address_rd2 != '0)                 rdata2 = regs_q[address_rd2];
        end
    end

    // Busy clears early when the last pending write retires this cycle (bypass covers it).
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (!reset) begin
            rs1_busy = (address_rd1 != '0) && (cnt_q[address_rd1] != '0) &&
                       !((cnt_q[address_rd1] == PEND_W'(1)) && dec_rd1);
            rs2_busy = (address_rd2 != '0) && (cnt_q[address_rd2] != '0) &&
                       !((cnt_q[address_rd2] == PEND_W'(1)) && dec_rd2);
        end
    end

    // Pending counters: issue increments, writeback decrements, both together cancel.
    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r != 0) begin
                logic inc;
                logic dec;
                inc = issue_en && issue_ok && (issue_rd == AW'(r));
                dec = wr_en && (address_wr == AW'(r)) && (cnt_q[r] != '0);
                if (inc && !dec)      cnt_d[r] = cnt_q[r] + PEND_W'(1);
                else if (dec && !inc) cnt_d[r] = cnt_q[r] - PEND_W'(1);
            end else begin
                cnt_d[r] = '0;
            end
        end
    end

    assign err_d = err_q || (wr_live && (cnt_q[address_wr] == '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (wr_live) regs_q[address_wr] <= data_in;
            for (int unsigned r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
            err_q <= err_d;
        end
    end

    assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scenario bench for reg_file_sb: expectations are queued as stimulus is driven
// and popped when the corresponding DUT output is sampled.
module tb_reg_file_sb;

    logic        clk;
    logic        reset;
    logic [4:0]  address_rd1;
    logic [4:0]  address_rd2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        issue_ok;
    logic        wr_en;
    logic [4:0]  address_wr;
    logic [31:0] data_in;
    logic        err_underflow;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    reg_file_sb dut (
        .clk(clk), .reset(reset),
        .address_rd1(address_rd1), .address_rd2(address_rd2),
        .rdata1(rdata1), .rdata2(rdata2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .issue_en(issue_en), .issue_rd(issue_rd), .issue_ok(issue_ok),
        .wr_en(wr_en), .address_wr(address_wr), .data_in(data_in),
        .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_en = 1'b0; issue_rd = '0;
        wr_en = 1'b0; address_wr = '0; data_in = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; address_rd1 = '0; address_rd2 = '0; idle();
        tick(); tick();
        #2 reset = 1'b0;
        tick();
        for (int r = 0; r < 32; r++) begin
            address_rd1 = 5'(r); address_rd2 = 5'(31 - r);
            exp_q.push_back(32'h0); exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            #1;
            e = exp_q.pop_front(); checks++;
            if (rdata1 !== e) begin errors++; $display("FAIL reset_rdata1 r=%0d got %h exp %h", r, rdata1, e); end
            e = exp_q.pop_front(); checks++;
            if (rdata2 !== e) begin errors++; $display("FAIL reset_rdata2 r=%0d got %h exp %h", r, rdata2, e); end
            e = exp_q.pop_front(); checks++;
            if ({30'b0, rs1_busy, rs2_busy} !== e) begin errors++; $display("FAIL reset_busy r=%0d got %b%b exp 00", r, rs1_busy, rs2_busy); end
        end
        checks++;
        if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_underflow); end
    endtask

    task automatic test_raw_bypass();
        idle(); issue_en = 1'b1; issue_rd = 5'd5; address_rd1 = 5'd5;
        exp_q.push_back(32'h1);
        #1 e = exp_q.pop_front(); checks++;
        if ({31'b0, issue_ok} !== e) begin errors++; $display("FAIL raw_issue_ok got %b exp %0d", issue_ok, e); end
        tick(); idle();
        exp_q.push_back(32'h1);
        #1 e = exp_q.pop_front(); checks++;
        if ({31'b0, rs1_busy} !== e) begin errors++; $display("FAIL raw_busy got %b exp %0d", rs1_busy, e); end
        wr_en = 1'b1; address_wr = 5'd5; data_in = 32'hDEADBEEF;
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'h0);
        #1 e = exp_q.pop_front(); checks++;
        if (rdata1 !== e) begin errors++; $display("FAIL raw_bypass got %h exp %h", rdata1, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'b0, rs1_busy} !== e) begin errors++; $display("FAIL raw_bypass_busy got %b exp %0d", rs1_busy, e); end
        tick(); idle();
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'h0);
        #1 e = exp_q.pop_front(); checks++;
        if (rdata1 !== e) begin errors++; $display("FAIL raw_after got %h exp %h", rdata1, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'b0, rs1_busy} !== e) begin errors++; $display("FAIL raw_after_busy got %b exp %0d", rs1_busy, e); end
    endtask

    task automatic test_saturate();
        idle(); address_rd1 = 5'd7;
        for (int i = 0; i < 3; i++) begin
            issue_en = 1'b1; issue_rd = 5'd7;
            exp_q.push_back(32'h1);
            #1 e = exp_q.pop_front(); checks++;
            if ({31'b0, issue_ok} !== e) begin errors++; $display("FAIL sat_issue%0d got %b exp %0d", i, issue_ok, e); end
            tick();
        end
        exp_q.push_back(32'h0);
        #1 e = exp_q.pop_front(); checks++;
        if ({31'b0, issue_ok} !== e) begin errors++; $display("FAIL sat_full_issue_ok got %b exp %0d", issue_ok, e); end
        tick();
        wr_en = 1'b1; address_wr = 5'd7; data_in = 32'h77;
        exp_q.push_back(32'h1);
        #1 e = exp_q.pop_front(); checks++;
        if ({31'b0, issue_ok} !== e) begin errors++; $display("FAIL sat_freed_issue_ok got %b exp %0d", issue_ok, e); end
        tick(); idle();
        // Counter must still be 3: two drains keep it busy, the third clears it.
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; address_wr = 5'd7; data_in = 32'h700 + 32'(i);
            exp_q.push_back((i < 2) ? 32'h1 : 32'h0);
            #1 e = exp_q.pop_front(); checks++;
            if ({31'b0, rs1_busy} !== e) begin errors++; $display("FAIL sat_drain%0d_busy got %b exp %0d", i, rs1_busy, e); end
            tick();
        end
        idle();
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h702);
        #1 e = exp_q.pop_front(); checks++;
        if ({31'b0, rs1_busy} !== e) begin errors++; $display("FAIL sat_end_busy got %b exp %0d", rs1_busy, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'b0, err_underflow} !== e) begin errors++; $display("FAIL sat_end_err got %b exp %0d", err_underflow, e); end
        e = exp_q.pop_front(); checks++;
        if (rdata1 !== e) begin errors++; $display("FAIL sat_end_data got %h exp %h", rdata1, e); end
    endtask

    task automatic test_r0();
        idle(); address_rd2 = 5'd0;
        wr_en = 1'b1; address_wr = 5'd0; data_in = 32'h1234;
        exp_q.push_back(32'h0);
        #1 e = exp_q.pop_front(); checks++;
        if (rdata2 !== e) begin errors++; $display("FAIL r0_same got %h exp %h", rdata2, e); end
        tick(); idle();
        issue_en = 1'b1; issue_rd = 5'd0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        #1 e = exp_q.pop_front(); checks++;
        if (rdata2 !== e) begin errors++; $display("FAIL r0_after got %h exp %h", rdata2, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'b0, issue_ok} !== e) begin errors++; $display("FAIL r0_issue_ok got %b exp %0d", issue_ok, e); end
        tick(); idle();
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1 e = exp_q.pop_front(); checks++;
        if ({31'b0, rs2_busy} !== e) begin errors++; $display("FAIL r0_busy got %b exp %0d", rs2_busy, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'b0, err_underflow} !== e) begin errors++; $display("FAIL r0_err got %b exp %0d", err_underflow, e); end
    endtask

    task automatic test_same_cycle();
        idle(); address_rd1 = 5'd3;
        issue_en = 1'b1; issue_rd = 5'd3;
        tick();
        wr_en = 1'b1; address_wr = 5'd3; data_in = 32'h33;
        exp_q.push_back(32'h1);
        #1 e = exp_q.pop_front(); checks++;
        if ({31'b0, issue_ok} !== e) begin errors++; $display("FAIL same_issue_ok got %b exp %0d", issue_ok, e); end
        tick(); idle();
        exp_q.push_back(32'h1); exp_q.push_back(32'h33);
        #1 e = exp_q.pop_front(); checks++;
        if ({31'b0, rs1_busy} !== e) begin errors++; $display("FAIL same_busy got %b exp %0d", rs1_busy, e); end
        e = exp_q.pop_front(); checks++;
        if (rdata1 !== e) begin errors++; $display("FAIL same_data got %h exp %h", rdata1, e); end
        wr_en = 1'b1; address_wr = 5'd3; data_in = 32'h34;
        tick(); idle();
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1 e = exp_q.pop_front(); checks++;
        if ({31'b0, rs1_busy} !== e) begin errors++; $display("FAIL same_drain_busy got %b exp %0d", rs1_busy, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'b0, err_underflow} !== e) begin errors++; $display("FAIL same_drain_err got %b exp %0d", err_underflow, e); end
    endtask

    task automatic test_underflow();
        idle(); address_rd1 = 5'd9;
        wr_en = 1'b1; address_wr = 5'd9; data_in = 32'h55;
        exp_q.push_back(32'h55); exp_q.push_back(32'h0);
        #1 e = exp_q.pop_front(); checks++;
        if (rdata1 !== e) begin errors++; $display("FAIL uf_bypass got %h exp %h", rdata1, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'b0, err_underflow} !== e) begin errors++; $display("FAIL uf_before got %b exp %0d", err_underflow, e); end
        tick(); idle();
        exp_q.push_back(32'h55); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        #1 e = exp_q.pop_front(); checks++;
        if (rdata1 !== e) begin errors++; $display("FAIL uf_data got %h exp %h", rdata1, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'b0, rs1_busy} !== e) begin errors++; $display("FAIL uf_busy got %b exp %0d", rs1_busy, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'b0, err_underflow} !== e) begin errors++; $display("FAIL uf_set got %b exp %0d", err_underflow, e); end
        tick(); tick();
        exp_q.push_back(32'h1);
        #1 e = exp_q.pop_front(); checks++;
        if ({31'b0, err_underflow} !== e) begin errors++; $display("FAIL uf_sticky got %b exp %0d", err_underflow, e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] model [32];
        logic [31:0] d;
        for (int r = 0; r < 32; r++) model[r] = 32'h0;
        model[5] = 32'hDEADBEEF; model[7] = 32'h702; model[9] = 32'h55; model[3] = 32'h34;
        idle();
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            wr_en = 1'b1; address_wr = 5'(10 + i); data_in = d; address_rd2 = 5'(10 + i);
            model[10 + i] = d;
            exp_q.push_back(d);
            #1 e = exp_q.pop_front(); checks++;
            if (rdata2 !== e) begin errors++; $display("FAIL b2b_bypass r=%0d got %h exp %h", 10 + i, rdata2, e); end
            tick();
        end
        idle();
        for (int r = 0; r < 32; r++) exp_q.push_back(model[r]);
        for (int r = 0; r < 32; r++) begin
            address_rd1 = 5'(r); address_rd2 = 5'(r);
            #1 e = exp_q.pop_front(); checks++;
            if (rdata1 !== e || rdata2 !== e) begin errors++; $display("FAIL b2b_read r=%0d got %h/%h exp %h", r, rdata1, rdata2, e); end
        end
    endtask

    task automatic test_mid_reset();
        idle(); address_rd1 = 5'd10; address_rd2 = 5'd11;
        issue_en = 1'b1; issue_rd = 5'd11;
        tick(); idle();
        exp_q.push_back(32'h1);
        #1 e = exp_q.pop_front(); checks++;
        if ({31'b0, rs2_busy} !== e) begin errors++; $display("FAIL mid_pre_busy got %b exp %0d", rs2_busy, e); end
        reset = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1 e = exp_q.pop_front(); checks++;
        if (rdata1 !== e) begin errors++; $display("FAIL mid_rdata1 got %h exp %h", rdata1, e); end
        e = exp_q.pop_front(); checks++;
        if (rdata2 !== e) begin errors++; $display("FAIL mid_rdata2 got %h exp %h", rdata2, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'b0, rs2_busy} !== e) begin errors++; $display("FAIL mid_busy got %b exp %0d", rs2_busy, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'b0, err_underflow} !== e) begin errors++; $display("FAIL mid_err got %b exp %0d", err_underflow, e); end
        #1 reset = 1'b0;
        tick();
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1 e = exp_q.pop_front(); checks++;
        if (rdata1 !== e) begin errors++; $display("FAIL mid_post_rdata1 got %h exp %h", rdata1, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'b0, rs2_busy} !== e) begin errors++; $display("FAIL mid_post_busy got %b exp %0d", rs2_busy, e); end
    endtask

    initial begin
        test_reset();
        test_raw_bypass();
        test_saturate();
        test_r0();
        test_same_cycle();
        test_underflow();
        test_back_to_back();
        test_mid_reset();
        if (exp_q.size() != 0) begin
            errors++; checks++;
            $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
